rf_wb_arbiter: RTL and testbench

//  Shares the register file's single write port between two writeback sources: ALU (req 0) and load/MEM (req 1).

---
 rtl/rf_wb_arbiter_pkg.sv | 24 ++
 rtl/rf_wb_arbiter_if.sv | 41 ++++
 rtl/rf_wb_arbiter_rr_arb2.sv | 61 ++++++
 rtl/rf_wb_arbiter.sv | 74 +++++++
 tb/tb_rf_wb_arbiter.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_pkg: shared constants and encodings for the regfile writeback arbiter.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package rf_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Writes to x0 are architecturally discarded.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Requester indices; also the bit positions in req/gnt vectors.
  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  // Arbitration policy encodings.
  typedef enum logic {
    PRIO_RR    = 1'b0,
    PRIO_FIXED = 1'b1
  } prio_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: ALU/MEM writeback requests plus the registered regfile write port.
// Latency: n/a (wiring only); readies are combinational, regfile port is registered.
// Backpressure: ready is the only throttle; the regfile side never stalls.
// Ports (signals): alu_/mem_ valid, ready, waddr, wdata; WrEn_RF, WAddr_RF, WD_RF; wb_cnt.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_waddr;
  logic [DATA_W-1:0] alu_wdata;

  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              WrEn_RF;
  logic [ADDR_W-1:0] WAddr_RF;
  logic [DATA_W-1:0] WD_RF;
  logic [15:0]       wb_cnt;

  // Requester side: drives requests, observes grants and the regfile port.
  modport master (
    output alu_valid, alu_waddr, alu_wdata,
    output mem_valid, mem_waddr, mem_wdata,
    input  alu_ready, mem_ready,
    input  WrEn_RF, WAddr_RF, WD_RF, wb_cnt
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_waddr, alu_wdata,
    input  mem_valid, mem_waddr, mem_wdata,
    output alu_ready, mem_ready,
    output WrEn_RF, WAddr_RF, WD_RF, wb_cnt
  );

endinterface

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// rr_arb2: 2-way arbiter, round-robin or MEM-first with an ALU starvation guard.
// Latency: grant is combinational from req and state; state updates at the edge.
// Backpressure: exactly one grant when any request is present; no grant in reset.
// Ports: clk, rst, i_req[1:0] (bit0 ALU, bit1 MEM), i_mode, o_gnt[1:0] one-hot.
module rr_arb2
  import rf_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  prio_e      i_mode,
  output logic [1:0] o_gnt
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  req_e       r_last;
  logic [3:0] r_wait_cnt;
  logic [1:0] w_gnt;

  always_comb begin
    w_gnt = 2'b00;
    if (rst) begin
      w_gnt = 2'b00;
    end else if (i_req == 2'b11) begin
      if (i_mode == PRIO_RR) begin
        w_gnt = (r_last == REQ_MEM) ? 2'b01 : 2'b10;
      end else begin
        // MEM-first unless ALU has already been passed over MAX_WAIT times.
        w_gnt = (r_wait_cnt == LP_MAX_WAIT) ? 2'b01 : 2'b10;
      end
    end else begin
      w_gnt = i_req;
    end
  end

  assign o_gnt = w_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last     <= REQ_MEM;
      r_wait_cnt <= 4'd0;
    end else begin
      if (w_gnt[0]) begin
        r_last <= REQ_ALU;
      end else if (w_gnt[1]) begin
        r_last <= REQ_MEM;
      end

      // Counts only cycles where ALU asked and MEM took the port instead.
      if (!i_req[0] || w_gnt[0]) begin
        r_wait_cnt <= 4'd0;
      end else if (i_mode == PRIO_FIXED && w_gnt[1] && r_wait_cnt != LP_MAX_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the regfile write port between ALU and MEM writebacks.
// Latency: accepted at edge N -> WrEn_RF/WAddr_RF/WD_RF valid N..N+1; wb_cnt counts at N+1.
// Backpressure: none downstream; a lone requester is ready the same cycle.
// Ports: clk, rst (sync, active-high), bus (rf_wb_arbiter_if.slave).
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W    = rf_pkg::DATA_W,
  parameter int ADDR_W    = rf_pkg::ADDR_W,
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  rf_wb_arbiter_if.slave    bus
);

  localparam prio_e LP_MODE = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_acc;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  logic              r_wren;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [15:0]       r_wb_cnt;

  assign w_req = {bus.mem_valid, bus.alu_valid};

  rr_arb2 #(
    .MAX_WAIT (MAX_WAIT)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_req  (w_req),
    .i_mode (LP_MODE),
    .o_gnt  (w_gnt)
  );

  assign bus.alu_ready = w_gnt[0];
  assign bus.mem_ready = w_gnt[1];

  // A grant is only ever issued to a valid requester, so any grant is a transfer.
  assign w_acc   = |w_gnt;
  assign w_waddr = w_gnt[1] ? bus.mem_waddr : bus.alu_waddr;
  assign w_wdata = w_gnt[1] ? bus.mem_wdata : bus.alu_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wren   <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
      r_wb_cnt <= 16'd0;
    end else begin
      // x0 writes complete the handshake but never assert the write enable.
      r_wren <= w_acc && (w_waddr != ADDR_W'(REG_ZERO));
      if (w_acc) begin
        r_waddr <= w_waddr;
        r_wdata <= w_wdata;
      end
      // Counted when the regfile commits, i.e. the edge ending a WrEn_RF cycle.
      r_wb_cnt <= r_wb_cnt + {15'd0, r_wren};
    end
  end

  assign bus.WrEn_RF  = r_wren;
  assign bus.WAddr_RF = r_waddr;
  assign bus.WD_RF    = r_wdata;
  assign bus.wb_cnt   = r_wb_cnt;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed checks of a round-robin and a fixed-priority arbiter instance.
// Both instances see identical requests; inputs change and outputs are sampled off the rising edge.
module tb_rf_wb_arbiter;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) if_rr ();
  rf_wb_arbiter_if #(.DATA_W(32), .ADDR_W(5)) if_fx ();

  // The fixed-priority instance mirrors the requests driven on the round-robin one.
  assign if_fx.alu_valid = if_rr.alu_valid;
  assign if_fx.alu_waddr = if_rr.alu_waddr;
  assign if_fx.alu_wdata = if_rr.alu_wdata;
  assign if_fx.mem_valid = if_rr.mem_valid;
  assign if_fx.mem_waddr = if_rr.mem_waddr;
  assign if_fx.mem_wdata = if_rr.mem_wdata;

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .PRIO_MODE(0), .MAX_WAIT(4)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (if_rr)
  );

  rf_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .PRIO_MODE(1), .MAX_WAIT(4)) u_fx (
    .clk (clk),
    .rst (rst),
    .bus (if_fx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk = n_chk + 1;
    if (obs === want) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;

    // Reset with both requesters asserting.
    rst              = 1'b1;
    if_rr.alu_valid  = 1'b1;
    if_rr.alu_waddr  = 5'd3;
    if_rr.alu_wdata  = 32'h0000_0033;
    if_rr.mem_valid  = 1'b1;
    if_rr.mem_waddr  = 5'd4;
    if_rr.mem_wdata  = 32'h0000_0044;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_rr_alu_ready", 32'(if_rr.alu_ready), 32'd0);
    chk("rst_rr_mem_ready", 32'(if_rr.mem_ready), 32'd0);
    chk("rst_fx_mem_ready", 32'(if_fx.mem_ready), 32'd0);
    chk("rst_wren",         32'(if_rr.WrEn_RF),   32'd0);
    chk("rst_waddr",        32'(if_rr.WAddr_RF),  32'd0);
    chk("rst_wd",           if_rr.WD_RF,          32'd0);
    chk("rst_cnt",          32'(if_rr.wb_cnt),    32'd0);

    // First cycle out of reset: round-robin ties go to ALU, fixed goes to MEM.
    rst = 1'b0;
    #1;
    chk("post_rst_rr_alu_ready", 32'(if_rr.alu_ready), 32'd1);
    chk("post_rst_rr_mem_ready", 32'(if_rr.mem_ready), 32'd0);
    chk("post_rst_fx_alu_ready", 32'(if_fx.alu_ready), 32'd0);
    chk("post_rst_fx_mem_ready", 32'(if_fx.mem_ready), 32'd1);
    // Withdraw before the edge: nothing is accepted.
    if_rr.mem_valid = 1'b0;

    // Single ALU request.
    if_rr.alu_valid = 1'b1;
    if_rr.alu_waddr = 5'd5;
    if_rr.alu_wdata = 32'hDEAD_BEEF;
    #1;
    chk("single_rr_alu_ready", 32'(if_rr.alu_ready), 32'd1);
    chk("single_fx_alu_ready", 32'(if_fx.alu_ready), 32'd1);
    @(negedge clk);
    if_rr.alu_valid = 1'b0;
    chk("single_wren",  32'(if_rr.WrEn_RF),  32'd1);
    chk("single_waddr", 32'(if_rr.WAddr_RF), 32'd5);
    chk("single_wd",    if_rr.WD_RF,         32'hDEAD_BEEF);
    chk("single_cnt0",  32'(if_rr.wb_cnt),   32'd0);
    @(negedge clk);
    chk("single_wren_low",   32'(if_rr.WrEn_RF),  32'd0);
    chk("single_waddr_hold", 32'(if_rr.WAddr_RF), 32'd5);
    chk("single_rr_cnt1",    32'(if_rr.wb_cnt),   32'd1);
    chk("single_fx_cnt1",    32'(if_fx.wb_cnt),   32'd1);

    // Continuous contention from a fresh reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if_rr.alu_valid = 1'b1;
    if_rr.alu_waddr = 5'd1;
    if_rr.alu_wdata = 32'h0000_00A1;
    if_rr.mem_valid = 1'b1;
    if_rr.mem_waddr = 5'd2;
    if_rr.mem_wdata = 32'h0000_00B2;
    for (int i = 0; i < 10; i++) begin
      logic rr_alu;
      logic fx_alu;
      rr_alu = (i % 2 == 0);
      fx_alu = (i % 5 == 4);
      #1;
      chk($sformatf("cont_rr_alu_ready[%0d]", i), 32'(if_rr.alu_ready), 32'(rr_alu));
      chk($sformatf("cont_rr_mem_ready[%0d]", i), 32'(if_rr.mem_ready), 32'(!rr_alu));
      chk($sformatf("cont_fx_alu_ready[%0d]", i), 32'(if_fx.alu_ready), 32'(fx_alu));
      chk($sformatf("cont_fx_mem_ready[%0d]", i), 32'(if_fx.mem_ready), 32'(!fx_alu));
      @(negedge clk);
      chk($sformatf("cont_rr_wren[%0d]", i),  32'(if_rr.WrEn_RF),  32'd1);
      chk($sformatf("cont_rr_waddr[%0d]", i), 32'(if_rr.WAddr_RF), rr_alu ? 32'd1 : 32'd2);
      chk($sformatf("cont_rr_wd[%0d]", i),    if_rr.WD_RF,         rr_alu ? 32'hA1 : 32'hB2);
      chk($sformatf("cont_rr_cnt[%0d]", i),   32'(if_rr.wb_cnt),   32'(i));
      chk($sformatf("cont_fx_waddr[%0d]", i), 32'(if_fx.WAddr_RF), fx_alu ? 32'd1 : 32'd2);
    end
    if_rr.alu_valid = 1'b0;
    if_rr.mem_valid = 1'b0;
    @(negedge clk);
    chk("cont_idle_wren", 32'(if_rr.WrEn_RF), 32'd0);
    chk("cont_rr_cnt10",  32'(if_rr.wb_cnt),  32'd10);
    chk("cont_fx_cnt10",  32'(if_fx.wb_cnt),  32'd10);

    // Write to x0: handshake completes, no regfile write, no count.
    if_rr.mem_valid = 1'b1;
    if_rr.mem_waddr = 5'd0;
    if_rr.mem_wdata = 32'h0000_1234;
    #1;
    chk("x0_rr_mem_ready", 32'(if_rr.mem_ready), 32'd1);
    chk("x0_fx_mem_ready", 32'(if_fx.mem_ready), 32'd1);
    @(negedge clk);
    if_rr.mem_valid = 1'b0;
    chk("x0_wren",  32'(if_rr.WrEn_RF),  32'd0);
    chk("x0_waddr", 32'(if_rr.WAddr_RF), 32'd0);
    chk("x0_wd",    if_rr.WD_RF,         32'h0000_1234);
    @(negedge clk);
    chk("x0_wren_after", 32'(if_rr.WrEn_RF), 32'd0);
    chk("x0_rr_cnt",     32'(if_rr.wb_cnt),  32'd10);
    chk("x0_fx_cnt",     32'(if_fx.wb_cnt),  32'd10);

    // Reset while an accepted write sits in the output register.
    if_rr.alu_valid = 1'b1;
    if_rr.alu_waddr = 5'd7;
    if_rr.alu_wdata = 32'h0000_0077;
    #1;
    chk("rstmid_alu_ready", 32'(if_rr.alu_ready), 32'd1);
    @(negedge clk);
    chk("rstmid_wren_pre",  32'(if_rr.WrEn_RF),  32'd1);
    chk("rstmid_waddr_pre", 32'(if_rr.WAddr_RF), 32'd7);
    rst = 1'b1;
    #1;
    chk("rstmid_ready_gated", 32'(if_rr.alu_ready), 32'd0);
    @(negedge clk);
    chk("rstmid_rr_wren",  32'(if_rr.WrEn_RF),  32'd0);
    chk("rstmid_rr_waddr", 32'(if_rr.WAddr_RF), 32'd0);
    chk("rstmid_rr_cnt",   32'(if_rr.wb_cnt),   32'd0);
    chk("rstmid_fx_wren",  32'(if_fx.WrEn_RF),  32'd0);
    chk("rstmid_fx_cnt",   32'(if_fx.wb_cnt),   32'd0);
    rst = 1'b0;
    if_rr.alu_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
